// File: rtl/ram_arbiter_2m.sv
// Round-robin arbiter sharing one 16x4096 single-port RAM between two masters.
// Latency: writes complete in the grant cycle; read data valid READ_LATENCY+1 cycles after grant.
// Backpressure: non-winners and all masters during a read wait see waitrequest high and hold inputs.
module ram_arbiter_2m #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] m0_address,
    input  logic        m0_write,
    input  logic        m0_read,
    input  logic [15:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [15:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [11:0] m1_address,
    input  logic        m1_write,
    input  logic        m1_read,
    input  logic [15:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [15:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [11:0] ram_address,
    output logic        ram_write,
    output logic        ram_read,
    output logic [15:0] ram_writedata,
    input  logic [15:0] ram_readdata
);

    typedef enum logic {IDLE, RDWAIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;      // remaining busy cycles minus one, so a latency of 4 fits in 2 bits
    logic        last, last_nxt;    // most recent winner
    logic        owner, owner_nxt;  // master whose read is in flight
    logic        capture;           // RAM read data is valid this cycle

    logic        req0, req1;
    logic        win;
    logic        grant;
    logic        sel_wr, sel_rd;
    logic [11:0] sel_addr;
    logic [15:0] sel_wdat;

    // Winner selection and RAM bus mux; only live in IDLE and outside reset
    always_comb begin
        req0     = m0_write | m0_read;
        req1     = m1_write | m1_read;
        win      = (req0 && req1) ? ~last : req1;
        grant    = (state == IDLE) && (req0 || req1) && !rst;
        sel_wr   = win ? m1_write     : m0_write;
        sel_rd   = win ? m1_read      : m0_read;
        sel_addr = win ? m1_address   : m0_address;
        sel_wdat = win ? m1_writedata : m0_writedata;

        ram_write      = grant && sel_wr;
        ram_read       = grant && sel_rd && !sel_wr;   // write wins over read on the same master
        ram_address    = grant ? sel_addr : 12'h000;
        ram_writedata  = grant ? sel_wdat : 16'h0000;
        m0_waitrequest = !(grant && !win);
        m1_waitrequest = !(grant && win);
    end

    // Next-state logic: grant handling in IDLE, latency countdown in RDWAIT
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        owner_nxt = owner;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    last_nxt = win;
                    if (!sel_wr) begin
                        owner_nxt = win;
                        cnt_nxt   = 2'(READ_LATENCY - 1);
                        state_nxt = RDWAIT;
                    end
                end
            end
            RDWAIT: begin
                if (cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, arbitration history and per-master read return registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 2'd0;
            last             <= 1'b1;
            owner            <= 1'b0;
            m0_readdata      <= 16'h0000;
            m1_readdata      <= 16'h0000;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            last             <= last_nxt;
            owner            <= owner_nxt;
            m0_readdatavalid <= capture && !owner;
            m1_readdatavalid <= capture && owner;
            if (capture && !owner)
                m0_readdata <= ram_readdata;
            if (capture && owner)
                m1_readdata <= ram_readdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter_2m.sv
// Bench for ram_arbiter_2m: one instance at read latency 1, one at read latency 3.
// Each instance drives a behavioural RAM; expected reads are queued at grant time.
// A negedge monitor pops and compares on every readdatavalid pulse.
module tb_ram_arbiter_2m;

    typedef struct {
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- instance with READ_LATENCY = 1 ----------------
    logic        rst1;
    logic [11:0] m0_address, m1_address, ram_address;
    logic        m0_write, m0_read, m1_write, m1_read;
    logic [15:0] m0_writedata, m1_writedata, ram_writedata, ram_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        ram_write, ram_read;

    ram_arbiter_2m #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_write(ram_write), .ram_read(ram_read),
        .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
    );

    logic [15:0] mem1 [4096];
    logic [15:0] pipe1;
    always @(posedge clk) begin
        if (ram_write) mem1[ram_address] <= ram_writedata;
        pipe1 <= mem1[ram_address];
    end
    assign ram_readdata = pipe1;

    // ---------------- instance with READ_LATENCY = 3 ----------------
    logic        rst3;
    logic [11:0] l3_m0_address, l3_m1_address, l3_ram_address;
    logic        l3_m0_read, l3_m1_read;
    logic        l3_m0_waitrequest, l3_m1_waitrequest;
    logic [15:0] l3_m0_readdata, l3_m1_readdata, l3_ram_writedata, l3_ram_readdata;
    logic        l3_m0_readdatavalid, l3_m1_readdatavalid;
    logic        l3_ram_write, l3_ram_read;
    logic        l3_zero1 = 1'b0;
    logic [15:0] l3_zero16 = 16'h0000;

    ram_arbiter_2m #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .m0_address(l3_m0_address), .m0_write(l3_zero1), .m0_read(l3_m0_read),
        .m0_writedata(l3_zero16), .m0_waitrequest(l3_m0_waitrequest),
        .m0_readdata(l3_m0_readdata), .m0_readdatavalid(l3_m0_readdatavalid),
        .m1_address(l3_m1_address), .m1_write(l3_zero1), .m1_read(l3_m1_read),
        .m1_writedata(l3_zero16), .m1_waitrequest(l3_m1_waitrequest),
        .m1_readdata(l3_m1_readdata), .m1_readdatavalid(l3_m1_readdatavalid),
        .ram_address(l3_ram_address), .ram_write(l3_ram_write), .ram_read(l3_ram_read),
        .ram_writedata(l3_ram_writedata), .ram_readdata(l3_ram_readdata)
    );

    logic [15:0] mem3 [4096];
    logic [15:0] pipe3 [3];
    always @(posedge clk) begin
        if (l3_ram_write) mem3[l3_ram_address] <= l3_ram_writedata;
        pipe3[0] <= mem3[l3_ram_address];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign l3_ram_readdata = pipe3[2];

    // ---------------- scoreboard ----------------
    exp_t q0[$];
    exp_t q1[$];
    exp_t q3[$];
    bit   glog[$];
    bit   log_en = 1'b0;
    int   v1_cyc = -1;
    int   l3_v0_cnt = 0;

    // Monitor for the latency-1 instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst1) begin
            if (m0_readdatavalid) begin
                if (q0.size() == 0) chk("m0 unexpected readdatavalid", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("m0 readdata", m0_readdata, e.dat);
                    chk("m0 readdatavalid cycle", cyc, e.cyc);
                end
            end
            if (m1_readdatavalid) begin
                v1_cyc = cyc;
                if (q1.size() == 0) chk("m1 unexpected readdatavalid", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("m1 readdata", m1_readdata, e.dat);
                    chk("m1 readdatavalid cycle", cyc, e.cyc);
                end
            end
            if (ram_read || ram_write) begin
                chk("exactly one waitrequest low", {m0_waitrequest, m1_waitrequest} == 2'b01 ||
                    {m0_waitrequest, m1_waitrequest} == 2'b10, 1);
                if (log_en) glog.push_back(!m1_waitrequest);
            end
        end
    end

    // Monitor for the latency-3 instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst3) begin
            if (l3_m0_readdatavalid) l3_v0_cnt++;
            if (l3_m1_readdatavalid) begin
                if (q3.size() == 0) chk("l3 m1 unexpected readdatavalid", 1, 0);
                else begin
                    e = q3.pop_front();
                    chk("l3 m1 readdata", l3_m1_readdata, e.dat);
                    chk("l3 m1 readdatavalid cycle", cyc, e.cyc);
                end
            end
        end
    end

    // ---------------- master drivers ----------------
    task automatic m0_txn(input logic wr, input logic rd, input logic [11:0] a, input logic [15:0] d,
                          output int waited, output int gcyc);
        m0_write = wr; m0_read = rd; m0_address = a; m0_writedata = d;
        waited = 0; gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!m0_waitrequest) begin gcyc = cyc; break; end
            waited++;
        end
        if (gcyc < 0) chk("m0 grant timeout", 0, 1);
        @(posedge clk); #1;
        m0_write = 1'b0; m0_read = 1'b0;
    endtask

    task automatic m1_txn(input logic wr, input logic rd, input logic [11:0] a, input logic [15:0] d,
                          output int waited, output int gcyc);
        m1_write = wr; m1_read = rd; m1_address = a; m1_writedata = d;
        waited = 0; gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!m1_waitrequest) begin gcyc = cyc; break; end
            waited++;
        end
        if (gcyc < 0) chk("m1 grant timeout", 0, 1);
        @(posedge clk); #1;
        m1_write = 1'b0; m1_read = 1'b0;
    endtask

    task automatic l3_rd(input bit m, input logic [11:0] a, output int gcyc);
        if (m) begin l3_m1_read = 1'b1; l3_m1_address = a; end
        else   begin l3_m0_read = 1'b1; l3_m0_address = a; end
        gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m ? !l3_m1_waitrequest : !l3_m0_waitrequest) begin gcyc = cyc; break; end
        end
        if (gcyc < 0) chk("l3 grant timeout", 0, 1);
        @(posedge clk); #1;
        l3_m0_read = 1'b0; l3_m1_read = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q3.size()) != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("outstanding reads drained", q0.size() + q1.size() + q3.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int w, g, g2;
        m0_address = '0; m0_write = 0; m0_read = 0; m0_writedata = '0;
        m1_address = '0; m1_write = 0; m1_read = 0; m1_writedata = '0;
        l3_m0_address = '0; l3_m1_address = '0; l3_m0_read = 0; l3_m1_read = 0;
        rst1 = 1'b1; rst3 = 1'b1;
        for (int i = 0; i < 4096; i++) begin mem1[i] = 16'h0000; mem3[i] = 16'h0000; end
        mem1[12'h100] = 16'h1111;
        mem1[12'h101] = 16'h2222;
        mem1[12'h0FF] = 16'h3333;
        mem3[12'h050] = 16'h6666;
        mem3[12'h040] = 16'h7777;

        // Reset holds the bus idle even with a request present
        @(posedge clk); #1;
        m0_read = 1'b1;
        @(negedge clk);
        chk("reset ram_read", ram_read, 0);
        chk("reset m0_waitrequest", m0_waitrequest, 1);
        m0_read = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b0; rst3 = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle strobes/valids", {ram_read, ram_write, m0_readdatavalid, m1_readdatavalid}, 0);
        end
        chk("reset readdata", {m0_readdata, m1_readdata}, 32'h0);
        @(posedge clk); #1;

        // Write then read back at latency 1
        m0_txn(1, 0, 12'h010, 16'h1234, w, g);
        chk("m0 write wait cycles", w, 0);
        m0_txn(0, 1, 12'h010, 16'h0000, w, g);
        q0.push_back('{dat: 16'h1234, cyc: g + 2});
        drain();

        // Fairness from reset with both masters reading continuously
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        log_en = 1'b1;
        fork
            begin
                int wa, ga;
                repeat (2) begin
                    m0_txn(0, 1, 12'h100, 16'h0000, wa, ga);
                    q0.push_back('{dat: 16'h1111, cyc: ga + 2});
                end
            end
            begin
                int wb, gb;
                repeat (2) begin
                    m1_txn(0, 1, 12'h101, 16'h0000, wb, gb);
                    q1.push_back('{dat: 16'h2222, cyc: gb + 2});
                end
            end
        join
        drain();
        log_en = 1'b0;
        chk("grant count", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("grant order 0", glog[0], 0);
            chk("grant order 1", glog[1], 1);
            chk("grant order 2", glog[2], 0);
            chk("grant order 3", glog[3], 1);
        end

        // m0 write waits behind an m1 read, granted in the m1 readdatavalid cycle
        m1_txn(0, 1, 12'h0FF, 16'h0000, w, g);
        q1.push_back('{dat: 16'h3333, cyc: g + 2});
        m0_txn(1, 0, 12'h030, 16'h5555, w, g2);
        chk("m0 write stalled cycles", w, 1);
        chk("m0 write grant at m1 rvalid", g2, v1_cyc);
        drain();
        chk("m0 readdata untouched", m0_readdata, 16'h1111);

        // Read and write together: write wins, no read return
        m0_txn(1, 1, 12'h020, 16'hBEEF, w, g);
        chk("rw write wait cycles", w, 0);
        repeat (4) @(posedge clk);
        #1;
        m0_txn(0, 1, 12'h020, 16'h0000, w, g);
        q0.push_back('{dat: 16'hBEEF, cyc: g + 2});
        drain();

        // Latency 3: reset in the second RDWAIT cycle abandons the read
        l3_rd(0, 12'h050, g);
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abandoned read no m0 valid", l3_v0_cnt, 0);
        chk("abandoned read m0 readdata", l3_m0_readdata, 16'h0000);
        l3_rd(1, 12'h040, g);
        q3.push_back('{dat: 16'h7777, cyc: g + 4});
        drain();
        chk("l3 m0 valid count final", l3_v0_cnt, 0);

        chk("final queues empty", q0.size() + q1.size() + q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global timeout actual=%0d required=finish", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
